// File: rtl/aes_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// aes_ctrl_pkg
//   Shared definitions for the iterative AES round sequencer: the controller
//   state encoding and the round counts / data width of the supported key
//   sizes.
// -----------------------------------------------------------------------------
package aes_ctrl_pkg;

  // Controller states: waiting for a block, iterating rounds, holding the
  // ciphertext until the consumer takes it.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int NR_AES128 = 10;
  localparam int NR_AES256 = 14;
  localparam int DW        = 128;

endpackage : aes_ctrl_pkg

// File: rtl/aes_round_sched.sv
// -----------------------------------------------------------------------------
// aes_round_sched
//   Iterative AES encryption sequencer. One external combinational round core
//   (sub_bytes -> shift_rows -> mix_columns -> key XOR) is time-shared across
//   all NR rounds. The sequencer does the initial key whitening (pt ^ k0)
//   itself, walks the round-key index through the external key store and
//   presents the finished block on a valid/ready output.
//
//   A block accepted on edge E0 runs NR ROUND cycles; out_valid rises after
//   edge E0+NR. If a new block is offered while the consumer takes the
//   current one, both handshakes complete on the same edge, giving one block
//   per NR+1 cycles.
//
// Ports
//   clk          system clock, rising edge
//   asy_reset    asynchronous active-low reset
//   flush        synchronous abort back to IDLE, overrides every handshake
//   in_valid     plaintext block offered
//   in_ready     block can be accepted this cycle
//   pt           plaintext, sampled on the accept edge only
//   rk_idx       round-key index to the key store
//   rk           round key for rk_idx (combinational, same cycle)
//   round_in     state fed to the round core
//   final_round  tells the round core to bypass mix_columns
//   round_out    combinational round-core result for round_in/rk
//   out_valid    ciphertext available
//   out_ready    consumer takes the ciphertext
//   ct           ciphertext
//   busy         high while rounds are being computed
//
//   The round counter must be able to hold NR, i.e. 2**CW > NR.
// -----------------------------------------------------------------------------
module aes_round_sched #(
  parameter int NR = aes_ctrl_pkg::NR_AES128,
  parameter int DW = aes_ctrl_pkg::DW,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          asy_reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] pt,
  output logic [CW-1:0] rk_idx,
  input  logic [DW-1:0] rk,
  output logic [DW-1:0] round_in,
  output logic          final_round,
  input  logic [DW-1:0] round_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] ct,
  output logic          busy
);

  import aes_ctrl_pkg::state_e;
  import aes_ctrl_pkg::IDLE;
  import aes_ctrl_pkg::ROUND;
  import aes_ctrl_pkg::DONE;

  localparam logic [CW-1:0] LAST_RND = CW'(NR);

  state_e        state_q,     state_d;
  logic [DW-1:0] state_reg_q, state_reg_d;
  logic [CW-1:0] rnd_cnt_q,   rnd_cnt_d;
  logic          accept;

  // A new block is taken from IDLE, or from DONE on the very edge the
  // consumer takes the previous ciphertext. flush blocks any accept.
  assign in_ready = !flush && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    state_reg_d = state_reg_q;
    rnd_cnt_d   = rnd_cnt_q;

    if (flush) begin
      state_d     = IDLE;
      state_reg_d = '0;
      rnd_cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            // rk_idx is 0 here, so rk is the whitening key k0.
            state_reg_d = pt ^ rk;
            rnd_cnt_d   = CW'(1);
            state_d     = ROUND;
          end
        end

        ROUND: begin
          state_reg_d = round_out;
          if (rnd_cnt_q == LAST_RND) begin
            // Counter parks at NR in DONE and never wraps.
            state_d = DONE;
          end else begin
            rnd_cnt_d = rnd_cnt_q + CW'(1);
          end
        end

        DONE: begin
          if (out_ready) begin
            if (accept) begin
              // Output handshake and new accept on the same edge: whiten the
              // next block and go straight back to the rounds.
              state_reg_d = pt ^ rk;
              rnd_cnt_d   = CW'(1);
              state_d     = ROUND;
            end else begin
              rnd_cnt_d = '0;
              state_d   = IDLE;
            end
          end
        end

        default: begin
          state_d     = IDLE;
          state_reg_d = '0;
          rnd_cnt_d   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: the data register is reset along with the control state so that a
  // block lost to reset never leaks its partial state onto round_in or ct.
  always_ff @(posedge clk or negedge asy_reset) begin
    if (!asy_reset) begin
      state_q     <= IDLE;
      state_reg_q <= '0;
      rnd_cnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      state_reg_q <= state_reg_d;
      rnd_cnt_q   <= rnd_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from registered state only
  // ---------------------------------------------------------------------------
  assign busy        = (state_q == ROUND);
  assign out_valid   = (state_q == DONE);
  assign rk_idx      = busy ? rnd_cnt_q : '0;
  assign final_round = busy && (rnd_cnt_q == LAST_RND);
  assign round_in    = state_reg_q;
  assign ct          = state_reg_q;

endmodule : aes_round_sched

// File: tb/tb_aes_round_sched.sv
// -----------------------------------------------------------------------------
// tb_aes_round_sched
//   Bench for aes_round_sched. Provides a behavioural AES round core and key
//   store around two instances (AES-128, NR=10 and AES-256, NR=14). Expected
//   ciphertexts are the published FIPS-197 vectors, pushed into a scoreboard
//   on accept and compared when the output handshake happens.
// -----------------------------------------------------------------------------
module tb_aes_round_sched;

  localparam int NR  = 10;
  localparam int NR2 = 14;

  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

  // ---------------------------------------------------------------------------
  // AES reference functions (round core and key expansion)
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from the GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic fin);
    logic [127:0] t;
    logic [127:0] u;
    logic [7:0]   a0, a1, a2, a3;
    for (int i = 0; i < 16; i++) begin
      int r, c, src;
      r   = i % 4;
      c   = i / 4;
      src = r + 4 * ((c + r) % 4);
      t[127-8*i -: 8] = sbox(s[127-8*src -: 8]);
    end
    u = t;
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[127-32*c -: 8];
        a1 = t[119-32*c -: 8];
        a2 = t[111-32*c -: 8];
        a3 = t[103-32*c -: 8];
        u[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        u[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        u[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        u[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    return u ^ k;
  endfunction

  // Key expansion for nk=4 (key in the upper 128 bits) or nk=8.
  function automatic logic [14:0][127:0] expand(input logic [255:0] key, input int nk);
    logic [31:0]        w [0:59];
    logic [31:0]        tmp;
    logic [7:0]         rc;
    logic [14:0][127:0] ks;
    int                 nw;
    nw = (nk == 4) ? 44 : 60;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int r = 0; r < 15; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ks;
  endfunction

  // ---------------------------------------------------------------------------
  // DUT signals, clock
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         asy_reset, flush, in_valid, in_ready, final_round, out_valid, out_ready, busy;
  logic [127:0] pt, rk, round_in, round_out, ct;
  logic [3:0]   rk_idx;

  logic         in_valid14, in_ready14, final_round14, out_valid14, busy14;
  logic [127:0] pt14, rk14, round_in14, round_out14, ct14;
  logic [3:0]   rk_idx14;

  always #5 clk = ~clk;

  aes_round_sched #(.NR(NR), .DW(128), .CW(4)) dut (
    .clk(clk), .asy_reset(asy_reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .pt(pt),
    .rk_idx(rk_idx), .rk(rk), .round_in(round_in), .final_round(final_round),
    .round_out(round_out), .out_valid(out_valid), .out_ready(out_ready),
    .ct(ct), .busy(busy)
  );

  aes_round_sched #(.NR(NR2), .DW(128), .CW(4)) dut14 (
    .clk(clk), .asy_reset(asy_reset), .flush(1'b0),
    .in_valid(in_valid14), .in_ready(in_ready14), .pt(pt14),
    .rk_idx(rk_idx14), .rk(rk14), .round_in(round_in14), .final_round(final_round14),
    .round_out(round_out14), .out_valid(out_valid14), .out_ready(1'b1),
    .ct(ct14), .busy(busy14)
  );

  // Key store: index 0 serves the block being offered (whitening on accept),
  // other indices serve the block in flight.
  logic [14:0][127:0] keys [0:1];
  logic [14:0][127:0] keys256;
  int                 offer_sel = 0;
  int                 fly_sel   = 0;

  always_comb begin
    rk          = (rk_idx == 4'd0) ? keys[offer_sel][0] : keys[fly_sel][rk_idx];
    round_out   = aes_round(round_in, rk, final_round);
    rk14        = keys256[rk_idx14];
    round_out14 = aes_round(round_in14, rk14, final_round14);
  end

  // ---------------------------------------------------------------------------
  // Checking and scoreboard
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [127:0] ct;
    int           acc;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         sb_tmp;
  bit           front_seen = 1'b0;
  logic [127:0] exp_offer;
  int           pop_log[$];
  int           acc_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples on the falling edge; a handshake seen here completes on
  // the following rising edge (cycle number cyc+1).
  always @(negedge clk) begin
    if (asy_reset) begin
      if (flush) begin
        sb_q.delete();
        front_seen = 1'b0;
      end else begin
        if (busy) begin
          if (sb_q.size() > 0) begin
            int k;
            k = cyc - sb_q[0].acc + 1;
            check("rk_idx_round", 128'(rk_idx), 128'(k));
            check("final_round", 128'(final_round), 128'(k == NR));
          end
        end else begin
          check("rk_idx_zero", 128'(rk_idx), 128'd0);
          check("final_round_low", 128'(final_round), 128'd0);
        end
        if (out_valid) begin
          if (sb_q.size() == 0) begin
            check("out_valid_unexpected", 128'(out_valid), 128'd0);
          end else begin
            if (!front_seen) begin
              check("latency", 128'(cyc - sb_q[0].acc), 128'(NR));
              front_seen = 1'b1;
            end
            check("ct", ct, sb_q[0].ct);
            if (out_ready) begin
              pop_log.push_back(cyc + 1);
              sb_tmp     = sb_q.pop_front();
              front_seen = 1'b0;
            end else begin
              check("in_ready_hold", 128'(in_ready), 128'd0);
            end
          end
        end
        if (in_valid && in_ready) begin
          sb_tmp.ct  = exp_offer;
          sb_tmp.acc = cyc + 1;
          sb_q.push_back(sb_tmp);
          acc_log.push_back(cyc + 1);
          fly_sel = offer_sel;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Offer a block and return just after the edge that accepts it.
  task automatic send(input logic [127:0] p, input int sel, input logic [127:0] e);
    bit got;
    got       = 1'b0;
    pt        = p;
    offer_sel = sel;
    exp_offer = e;
    in_valid  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      got = in_valid && in_ready;
      tick();
      if (got) break;
    end
    check("accept", 128'(got), 128'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (sb_q.size() == 0) break;
      tick();
    end
    check("drain", 128'(sb_q.size()), 128'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_out_valid"}, 128'(out_valid), 128'd0);
    check({tag, "_busy"}, 128'(busy), 128'd0);
    check({tag, "_final"}, 128'(final_round), 128'd0);
    check({tag, "_rk_idx"}, 128'(rk_idx), 128'd0);
    check({tag, "_in_ready"}, 128'(in_ready), 128'd1);
    check({tag, "_round_in"}, round_in, 128'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    keys[0]    = expand({C1_KEY, 128'h0}, 4);
    keys[1]    = expand({B_KEY, 128'h0}, 4);
    keys256    = expand(C3_KEY, 8);
    asy_reset  = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    pt         = '0;
    exp_offer  = '0;
    in_valid14 = 1'b0;
    pt14       = '0;

    #1;
    check_reset_vals("por");
    tick();
    tick();
    asy_reset = 1'b1;
    tick();

    // FIPS-197 C.1, consumer always ready.
    send(C1_PT, 0, C1_CT);
    in_valid = 1'b0;
    drain();

    // FIPS-197 B, consumer stalls 5 cycles after out_valid.
    out_ready = 1'b0;
    send(B_PT, 1, B_CT);
    in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) break;
      tick();
    end
    check("b_out_valid", 128'(out_valid), 128'd1);
    repeat (5) tick();
    out_ready = 1'b1;
    drain();

    // Back-to-back: second accept coincides with first output handshake.
    pop_log.delete();
    acc_log.delete();
    send(C1_PT, 0, C1_CT);
    send(B_PT, 1, B_CT);
    in_valid = 1'b0;
    drain();
    check("b2b_pops", 128'(pop_log.size()), 128'd2);
    check("b2b_accs", 128'(acc_log.size()), 128'd2);
    if (pop_log.size() == 2 && acc_log.size() == 2) begin
      check("b2b_spacing", 128'(pop_log[1] - pop_log[0]), 128'(NR + 1));
      check("b2b_overlap", 128'(acc_log[1]), 128'(pop_log[0]));
    end

    // flush in the 4th ROUND cycle.
    send(C1_PT, 0, C1_CT);
    in_valid = 1'b0;
    repeat (3) tick();
    check("flush_rnd4", 128'(rk_idx), 128'd4);
    flush = 1'b1;
    #1;
    check("flush_in_ready", 128'(in_ready), 128'd0);
    tick();
    flush = 1'b0;
    #1;
    check_reset_vals("flush");
    repeat (15) tick();
    send(C1_PT, 0, C1_CT);
    in_valid = 1'b0;
    drain();

    // Asynchronous reset between edges in mid-ROUND.
    send(B_PT, 1, B_CT);
    in_valid = 1'b0;
    repeat (2) tick();
    #1;
    check("rst_busy_before", 128'(busy), 128'd1);
    asy_reset = 1'b0;
    sb_q.delete();
    front_seen = 1'b0;
    #1;
    check_reset_vals("arst");
    #4;
    asy_reset = 1'b1;
    tick();
    send(C1_PT, 0, C1_CT);
    in_valid = 1'b0;
    drain();

    // AES-256 (FIPS-197 C.3) on the NR=14 instance.
    begin
      bit got;
      bit seen;
      int k;
      got        = 1'b0;
      seen       = 1'b0;
      k          = 1;
      pt14       = C1_PT;
      in_valid14 = 1'b1;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        got = in_ready14;
        check("a256_idle_rk_idx", 128'(rk_idx14), 128'd0);
        tick();
        if (got) break;
      end
      in_valid14 = 1'b0;
      check("a256_accept", 128'(got), 128'd1);
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (busy14) begin
          check("a256_rk_idx", 128'(rk_idx14), 128'(k));
          check("a256_final", 128'(final_round14), 128'(k == NR2));
          k++;
        end
        if (out_valid14) begin
          seen = 1'b1;
          check("a256_rounds", 128'(k - 1), 128'(NR2));
          check("a256_ct", ct14, C3_CT);
          tick();
          break;
        end
        tick();
      end
      check("a256_out_valid", 128'(seen), 128'd1);
      check("a256_idle_after", 128'(out_valid14), 128'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_aes_round_sched

// File: doc/aes_round_sched.md
Name: aes_round_sched

Overview:
- Iterative AES encryption sequencer. It time-shares one external single-round datapath (sub_bytes -> shift_row -> mix_columns -> key XOR) across all NR rounds.
- Performs the initial key whitening itself and indexes round keys from an external key store.
- Sits between the block-level valid/ready interface and the round core. The cipher supplies round keys and the combinational round result.

Parameters:
- NR, 10, number of rounds: 10 for AES-128, 14 for AES-256.
- DW, 128, state/key width in bits.
- CW, 4, width of round counter and rk_idx; must satisfy 2^CW > NR.

Ports:
- clk  in  1  system clock, rising edge.
- asy_reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort; returns the block to IDLE.
- in_valid  in  1  plaintext block offered.
- in_ready  out  1  block can be accepted this cycle.
- pt  in  DW  plaintext; sampled only on the accept edge.
- rk_idx  out  CW  round-key index to the key store.
- rk  in  DW  round key for rk_idx; combinational, same cycle.
- round_in  out  DW  state fed to the round core (= state_reg).
- final_round  out  1  instructs the round core to bypass mix_columns.
- round_out  in  DW  combinational round-core result for round_in/rk.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  consumer takes ciphertext.
- ct  out  DW  ciphertext (= state_reg while out_valid).
- busy  out  1  high in ROUND.

Behaviour:
- Reset (asy_reset=0, async):
  - FSM=IDLE, state_reg=0, rnd_cnt=0.
  - out_valid=0, busy=0, final_round=0, rk_idx=0.
  - in_ready=1 once the FSM is in IDLE.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1, rk_idx=0.
  - On in_valid&&in_ready: state_reg<=pt^rk (k0), rnd_cnt<=1, go to ROUND.
- ROUND:
  - busy=1, rk_idx=rnd_cnt, round_in=state_reg.
  - Each cycle: state_reg<=round_out, rnd_cnt<=rnd_cnt+1.
  - final_round=1 iff rnd_cnt==NR; on that cycle go to DONE.
- DONE:
  - out_valid=1, ct=state_reg, rk_idx=0. state_reg holds while out_ready=0.
  - On out_ready without a new accept: go to IDLE, rnd_cnt<=0.
- Back-to-back:
  - in_ready=(FSM==IDLE)||(FSM==DONE&&out_ready).
  - If DONE, out_ready and in_valid coincide: the output handshake completes, the new pt is whitened with k0, and the FSM goes directly to ROUND.
  - Throughput: one block per NR+1 cycles.
- Latency: the accept edge is E0. out_valid rises after edge E0+NR (NR ROUND cycles).
- rnd_cnt never exceeds NR. rnd_cnt=0 outside ROUND/DONE-to-accept paths; no wrap.
- flush has priority over every handshake. On the next edge:
  - IDLE, state_reg=0, rnd_cnt=0, out_valid=0.
  - A pending ct is discarded.
  - in_ready is forced to 0 in the flush cycle.
- Reset mid-operation (any state): immediate return to reset values; the partial block is lost with no output.
- pt and in_valid are ignored outside the accept condition. rk and round_out are don't-care outside ROUND, except rk in the accept cycle.
- All outputs except in_ready are registered or decoded from registered state only. in_ready additionally depends on out_ready.

Decomposition:
- Shared package aes_ctrl_pkg holds:
  - state enum {IDLE, ROUND, DONE};
  - NR_AES128=10, NR_AES256=14;
  - DW=128.
- No sub-module; the round counter is inline.
- The round core (sub_bytes/shift_row/mix_columns/Add_Round_Key chain with a mix_columns bypass) and key expansion stay outside this block.

Test Plan:
- FIPS-197 C.1: pt=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f, out_ready=1 -> out_valid exactly 10 cycles after accept, ct=69c4e0d86a7b0430d8cdb78070b4c55a. rk_idx sequence is 0,1..10, with final_round high only at rk_idx=10.
- FIPS-197 B: pt=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c, out_ready held 0 for 5 cycles after out_valid -> ct=3925841d02dc09fbdc118597196a0b32 stable throughout. in_ready=0 until out_ready.
- Back-to-back: in_valid held high with both vectors, out_ready=1 -> second accept coincides with the first output handshake, and ct values appear 11 cycles apart.
- flush asserted at the 4th ROUND cycle -> next cycle IDLE, in_ready=1, no out_valid. A following C.1 block still produces 69c4e0d8...c55a.
- asy_reset pulsed low mid-ROUND, asynchronously between edges -> outputs reach reset values without a clock edge. After release the block accepts and encrypts correctly.
- NR=14 build with AES-256 C.3 vector (key=000102...1e1f) -> ct=8ea2b7ca516745bfeafc49904b496089 after 14 cycles, with final_round high only at rk_idx=14.
